// File: rtl/byte_burst_feeder_if.sv
// Byte feeder bus: upstream valid/ready byte input, start request, and the
// detector-side outputs (det_clr, d_out) plus status.
interface byte_burst_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              start;
  logic              det_clr;
  logic [7:0]        d_out;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              ovf;

  modport master (
    output in_valid, in_data, start,
    input  in_ready, det_clr, d_out, busy, count, ovf
  );

  modport slave (
    input  in_valid, in_data, start,
    output in_ready, det_clr, d_out, busy, count, ovf
  );
endinterface

// File: rtl/byte_burst_feeder.sv
// Buffers sporadic bytes in a FIFO, then clears the downstream detector and
// replays the bytes on consecutive clocks. Overflow flag: BURST_FEEDER_OVF_EN.
//
// state    | meaning
// S_IDLE   | accept writes, wait for start with data available
// S_CLEAR  | det_clr high for one cycle, first pop at the end of it
// S_STREAM | one byte per clock on d_out until the FIFO drains
module byte_burst_feeder #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 clr,
  byte_burst_feeder_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        d_out_q, d_out_d;
  logic              det_clr_q, det_clr_d;
  logic              in_ready_w;
  logic              wr_en;
  logic              pop;

  assign in_ready_w = (state_q == S_IDLE) && (count_q != FULL);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    d_out_d   = d_out_q;
    det_clr_d = 1'b0;
    pop       = 1'b0;
    wr_en     = bus.in_valid && in_ready_w;

    case (state_q)
      S_IDLE: begin
        d_out_d = IDLE_BYTE;
        // a write on the same edge as start joins the burst
        if (bus.start && ((count_q != '0) || wr_en)) begin
          state_d   = S_CLEAR;
          det_clr_d = 1'b1;
        end
      end
      S_CLEAR: begin
        pop     = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end else begin
          state_d = S_IDLE;
          d_out_d = IDLE_BYTE;
        end
      end
      default: begin
        state_d = S_IDLE;
        d_out_d = IDLE_BYTE;
      end
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
      d_out_d  = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      d_out_q   <= IDLE_BYTE;
      det_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      d_out_q   <= d_out_d;
      det_clr_q <= det_clr_d;
    end
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

`ifdef BURST_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == S_IDLE) && (count_q == FULL) && bus.in_valid) begin
      ovf_d = 1'b1;
    end
    if (det_clr_d) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready = in_ready_w;
  assign bus.det_clr  = det_clr_q;
  assign bus.d_out    = d_out_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q == S_CLEAR) || (state_q == S_STREAM);

endmodule

// File: tb/tb_byte_burst_feeder.sv
// Directed sequence with randomized data and gaps, checked against a queue
// model of the buffered bytes and the burst timing.
module tb_byte_burst_feeder;
  localparam int         DEPTH  = 16;
  localparam int         ADDR_W = 4;
  localparam logic [7:0] IDLE   = 8'h00;
`ifdef BURST_FEEDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] model_q[$];
  bit   ovf_exp;

  byte_burst_feeder_if #(.ADDR_W(ADDR_W)) bus();

  byte_burst_feeder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDLE_BYTE(IDLE)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d_out"},   bus.d_out, IDLE);
    chk({tag, "_busy"},    bus.busy, 1'b0);
    chk({tag, "_det_clr"}, bus.det_clr, 1'b0);
    chk({tag, "_count"},   bus.count, model_q.size());
    chk({tag, "_ovf"},     bus.ovf, ovf_exp);
  endtask

  task automatic push(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    chk("in_ready", bus.in_ready, model_q.size() < DEPTH);
    tick();
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else if (OVF_ON) ovf_exp = 1'b1;
    bus.in_valid = 1'b0;
    chk_idle("push");
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk_idle("gap");
    end
  endtask

  task automatic burst(input bit with_wr, input logic [7:0] b, input bit hold);
    int n;
    bus.start = 1'b1;
    if (with_wr) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b;
    end
    tick();
    if (with_wr) begin
      model_q.push_back(b);
      bus.in_valid = 1'b0;
    end
    if (!hold) bus.start = 1'b0;
    n = model_q.size();
    ovf_exp = 1'b0;
    chk("clr_det_clr",  bus.det_clr, 1'b1);
    chk("clr_busy",     bus.busy, 1'b1);
    chk("clr_d_out",    bus.d_out, IDLE);
    chk("clr_in_ready", bus.in_ready, 1'b0);
    chk("clr_ovf",      bus.ovf, 1'b0);
    chk("clr_count",    bus.count, n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("str_d_out",   bus.d_out, model_q[k]);
      chk("str_det_clr", bus.det_clr, 1'b0);
      chk("str_busy",    bus.busy, 1'b1);
      chk("str_count",   bus.count, n - 1 - k);
    end
    model_q.delete();
    tick();
    chk_idle("burst_end");
    if (hold) begin
      tick();
      chk_idle("hold_start");
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] pat [8];
    pat = '{8'h6E, 8'h30, 8'h5F, 8'h73, 8'h50, 8'h31, 8'h63, 8'h33};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.start    = 1'b0;
    ovf_exp      = 1'b0;
    clr          = 1'b1;
    #12;
    chk_idle("reset");
    chk("reset_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    tick();

    // pattern burst with random gaps
    foreach (pat[i]) push(pat[i]);
    burst(1'b0, 8'h00, 1'b0);

    // start with nothing buffered
    bus.start = 1'b1;
    repeat (3) begin
      tick();
      chk_idle("empty_start");
    end
    bus.start = 1'b0;

    // fill, overflow drop, drain in order
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("full_in_ready", bus.in_ready, 1'b0);
    push(8'hAA);
    burst(1'b0, 8'h00, 1'b0);

    // start on the same edge as a write, start held through the burst
    push(8'($urandom));
    push(8'($urandom));
    burst(1'b1, 8'h41, 1'b1);

    // back-to-back bursts across the pointer wrap
    repeat (2) begin
      repeat (10) push(8'($urandom));
      burst(1'b0, 8'h00, 1'b0);
    end

    // async reset mid-stream
    repeat (8) push(8'($urandom));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("pre_abort_busy", bus.busy, 1'b1);
    #2;
    clr = 1'b1;
    #1;
    model_q.delete();
    ovf_exp = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    clr = 1'b0;
    bus.start = 1'b1;
    repeat (3) begin
      tick();
      chk_idle("post_abort_start");
    end
    bus.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_burst_feeder.md
Name: byte_burst_feeder

Overview:
- Upstream feeder for the byte-sequence detector (clk/clr, 8-bit d, one byte per clock, consecutive-cycle match chain).
- Collects bytes arriving sporadically (e.g. from a UART RX) on a valid/ready interface into a small FIFO.
- On start, pulses the detector clear, then replays the buffered bytes on strictly consecutive clocks so the detector's per-cycle chain sees an unbroken sequence.
- Drives a neutral idle byte at all other times.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH).
- IDLE_BYTE, 8'h00, value driven on d_out whenever no byte is being streamed.

Ports:
- clk  input  1  single clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  block can accept in_data this cycle.
- start  input  1  request to stream the buffered bytes; level-sampled.
- det_clr  output  1  one-cycle clear pulse to the downstream detector's clr.
- d_out  output  8  byte stream to the detector's d.
- busy  output  1  high in CLEAR and STREAM states.
- count  output  ADDR_W+1  number of bytes currently buffered, 0..DEPTH.
- ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (clr high, async): state IDLE; rd/wr pointers 0; count 0; d_out = IDLE_BYTE; det_clr 0; busy 0; ovf 0. Reset mid-STREAM aborts the burst and discards FIFO contents.
- All outputs are registered except in_ready and busy, which decode from state/count.
- in_ready = (state == IDLE) && (count != DEPTH). No writes are accepted during CLEAR or STREAM.
- Write: in_valid && in_ready at an edge stores in_data at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- States:
  - IDLE: if start && (count != 0 || write this edge), go to CLEAR. Start with an empty FIFO and no write is ignored. A same-edge write is accepted and included in the burst.
  - CLEAR: det_clr = 1 for exactly this one cycle; d_out = IDLE_BYTE. Next state is STREAM.
  - STREAM: on each edge, pop fifo[rd_ptr] into d_out, rd_ptr+1 (wraps), count-1. When the popped byte is the last one (count becomes 0), the next edge sets d_out = IDLE_BYTE and returns to IDLE.
- Latency: start sampled at edge T → det_clr high during T..T+1 → byte0 on d_out during T+1..T+2 → byte k during T+1+k..T+2+k.
- d_out never repeats or gaps mid-burst. busy is high for count+1 cycles.
- start held high through STREAM has no effect. After returning to IDLE, a still-high start with count 0 is ignored.
- Full FIFO: in_valid with in_ready low drops the byte silently (baseline). Pointers wrap cleanly at DEPTH.
- count arithmetic is ADDR_W+1 bits; simultaneous push and pop cannot occur.

Optional Feature:
- Macro: BURST_FEEDER_OVF_EN.
- Defined: ovf sets on any edge where in_valid=1 and in_ready=0 while in IDLE with count == DEPTH. It is sticky and clears on clr or on entry to CLEAR.
- Undefined: ovf is tied to 0 and no overflow logic is synthesized. The port remains present.

Test Plan:
- Write 0x6E,0x30,0x5F,0x73,0x50,0x31,0x63,0x33 with random gaps, then start → det_clr high 1 cycle; d_out = those 8 bytes on 8 consecutive cycles, then 0x00; busy high 9 cycles; count 8→0; a chained detector asserts q[8].
- Write 16 bytes (0x00..0x0F) → count 16, in_ready 0. 17th write 0xAA is dropped. With BURST_FEEDER_OVF_EN, ovf=1. Stream yields 0x00..0x0F in order.
- start with count 0 and no write → no det_clr, busy stays 0, d_out stays 0x00.
- In IDLE with count 2, assert start on the same edge as a write of 0x41 → burst streams 3 bytes, 0x41 last.
- Assert clr asynchronously mid-STREAM after 3 of 8 bytes → d_out 0x00, count 0, busy 0 immediately. A later start is ignored until new writes arrive.
- Two bursts back-to-back: 10 bytes then 10 bytes across the wrap → pointer wrap is correct and the second burst's data is intact.
